// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUControl codes, ALUOp classes and the mul/div sequencer states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_EXT   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply (mode=0) or restoring divide (mode=1).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] opa_o,
    output logic [XLEN-1:0] opb_o
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] quo_sh;
    logic            fits;

    // Remainder after shift needs XLEN+1 bits; the difference always fits in XLEN.
    assign rem_sh = {acc_i, opa_i[XLEN-1]};
    assign quo_sh = {opa_i[XLEN-2:0], 1'b0};
    assign fits   = (rem_sh >= {1'b0, opb_i});

    always_comb begin
        if (div_mode_i) begin
            acc_o = fits ? (rem_sh[XLEN-1:0] - opb_i) : rem_sh[XLEN-1:0];
            opa_o = {quo_sh[XLEN-1:1], fits};
            opb_o = opb_i;
        end else begin
            acc_o = opb_i[0] ? (acc_i + opa_i) : acc_i;
            opa_o = quo_sh;
            opb_o = {1'b0, opb_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL / DIVU sequencer with request and result valid/ready handshakes.
module alu_muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            stall
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] acc_n, opa_n, opb_n;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode_i (state_q == S_DIV),
        .acc_i      (acc_q),
        .opa_i      (opa_q),
        .opb_i      (opb_q),
        .acc_o      (acc_n),
        .opa_o      (opa_n),
        .opb_o      (opb_n)
    );

    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign stall       = (state_q != S_IDLE);
    assign result      = result_q;
    assign illegal     = illegal_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    cnt_d = '0;
                    acc_d = '0;
                    opa_d = src_a;
                    opb_d = src_b;
                    case (alu_ctrl)
                        ALU_MUL:  state_d = S_MUL;
                        ALU_DIVU: begin
                            if (src_b != '0) begin
                                state_d = S_DIV;
                            end else begin
                                state_d   = S_DONE;
                                result_d  = '1;
                                illegal_d = 1'b0;
                            end
                        end
                        default: begin
                            state_d   = S_DONE;
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                acc_d = acc_n;
                opa_d = opa_n;
                opb_d = opb_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d   = S_DONE;
                    result_d  = (state_q == S_MUL) ? acc_n : opa_n;
                    illegal_d = 1'b0;
                end
            end
            default: begin
                if (res_ready) state_d = S_IDLE;
            end
        endcase
        // Flush beats everything, including a same-cycle request.
        if (flush) begin
            state_d   = S_IDLE;
            result_d  = '0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer: vector table plus handshake/flush/reset sequences.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        illegal;
    logic        stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_sequencer #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .alu_ctrl    (alu_ctrl),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .illegal     (illegal),
        .stall       (stall)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat,
                          input string name);
        int cyc;
        alu_ctrl = ctrl; src_a = a; src_b = b; start_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        alu_ctrl = 4'hF; src_a = 32'hDEAD_BEEF; src_b = 32'h0;
        cyc = 1;
        check({name, " stall@1"}, {31'd0, stall}, 32'd1);
        while (!res_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, exp_lat);
        check({name, " result"}, result, exp_res);
        check({name, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        @(posedge clk); #1;
        check({name, " idle after"}, {30'd0, res_valid, start_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{4'b1000, 32'd7,          32'd6,          32'd42,         1'b0, 33};
        vecs[1] = '{4'b1001, 32'd100,        32'd7,          32'd14,         1'b0, 33};
        vecs[2] = '{4'b1001, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33};
        vecs[3] = '{4'b1000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 33};
        vecs[4] = '{4'b1001, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0, 1};
        vecs[5] = '{4'b0100, 32'd5,          32'd3,          32'd0,          1'b1, 1};
        vecs[6] = '{4'b1000, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0, 33};
        vecs[7] = '{4'b1001, 32'd7,          32'd100,        32'd0,          1'b0, 33};
        vecs[8] = '{4'b1001, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  1'b0, 33};
        vecs[9] = '{4'b1000, 32'd12345,      32'd1000,       32'd12345000,   1'b0, 33};

        reset = 1'b1; start_valid = 1'b0; alu_ctrl = 4'h0; src_a = '0; src_b = '0;
        flush = 1'b0; res_ready = 1'b0;
        #2;
        check("reset outputs", {28'd0, start_ready, res_valid, illegal, stall}, 32'b1000);
        check("reset result", result, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_ill,
                   vecs[i].exp_lat, $sformatf("vec%0d", i));

        // Backpressure: result held for 10 cycles while extra requests are offered.
        begin
            int cyc = 0;
            alu_ctrl = 4'b1000; src_a = 32'd3; src_b = 32'd5; start_valid = 1'b1; res_ready = 1'b0;
            @(posedge clk); #1;
            start_valid = 1'b0;
            while (!res_valid && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("bp reached done", {31'd0, res_valid}, 32'd1);
            start_valid = 1'b1; alu_ctrl = 4'b1001; src_a = 32'd50; src_b = 32'd2;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                check($sformatf("bp hold%0d", k),
                      {result[27:0], res_valid, stall, start_ready, illegal}, {28'd15, 4'b1100});
            end
            start_valid = 1'b0; res_ready = 1'b1;
            @(posedge clk); #1;
            check("bp handshake", {30'd0, res_valid, start_ready}, 32'd1);
            @(posedge clk); #1;
            check("bp no accept", {31'd0, stall}, 32'd0);
        end

        // Flush at cycle 15 of a MUL with a competing request in the same cycle.
        begin
            int seen = 0;
            alu_ctrl = 4'b1000; src_a = 32'd11; src_b = 32'd13; start_valid = 1'b1; res_ready = 1'b1;
            @(posedge clk); #1;
            start_valid = 1'b0;
            repeat (14) begin @(posedge clk); #1; end
            flush = 1'b1; start_valid = 1'b1; alu_ctrl = 4'b1000; src_a = 32'd2; src_b = 32'd2;
            @(posedge clk); #1;
            flush = 1'b0; start_valid = 1'b0;
            check("flush idle", {29'd0, stall, res_valid, start_ready}, 32'b001);
            repeat (40) begin
                @(posedge clk); #1;
                if (res_valid || stall) seen++;
            end
            check("flush quiet", seen, 32'd0);
        end
        run_op(4'b1000, 32'd3, 32'd3, 32'd9, 1'b0, 33, "mul3x3");

        // Asynchronous reset in the middle of a DIVU.
        alu_ctrl = 4'b1001; src_a = 32'd1000; src_b = 32'd7; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("async reset flags", {28'd0, start_ready, res_valid, illegal, stall}, 32'b1000);
        check("async reset result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(4'b1001, 32'd9, 32'd3, 32'd3, 1'b0, 33, "div9/3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Multi-cycle sequencer for the two extended ALU operations decoded under ALUOp=2'b11: ALUControl 4'b1000 = MUL (low XLEN bits of the product) and 4'b1001 = DIVU (unsigned quotient).
- Sits beside the single-cycle ALU. The core hands it a control code plus operands through a valid/ready handshake, holds `stall` while it iterates, and takes the result through a second valid/ready handshake.
- One iteration per clock: shift-add for MUL, restoring division for DIVU.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, iteration-counter width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_valid  input  1  request presents code and operands.
- start_ready  output  1  sequencer can accept a request.
- alu_ctrl  input  4  ALUControl code for the request.
- src_a  input  XLEN  multiplicand / dividend.
- src_b  input  XLEN  multiplier / divisor.
- flush  input  1  abort any operation in flight.
- res_valid  output  1  result is available.
- res_ready  input  1  consumer takes the result.
- result  output  XLEN  product low bits or quotient.
- illegal  output  1  qualifies result: the request code was not 1000/1001.
- stall  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, all internal registers=0, result=0, res_valid=0, illegal=0, stall=0, start_ready=1.
- States: IDLE, MUL, DIV, DONE.
- start_ready=1 only in IDLE.
- Accept: start_valid & start_ready sampled at a rising edge. That edge latches alu_ctrl/src_a/src_b and clears the counter.
- Transition taken on accept:
  - Code 1000 -> MUL. Accumulator=0, multiplicand=src_a, multiplier=src_b.
  - Code 1001 with src_b!=0 -> DIV. Remainder=0, quotient register=src_a, divisor=src_b.
  - Code 1001 with src_b==0 -> DONE directly. result = all ones (RISC-V divide-by-zero rule), illegal=0.
  - Any other code -> DONE directly. result=0, illegal=1.
- MUL, each edge:
  - If multiplier[0], accumulator += multiplicand (mod 2^XLEN).
  - multiplicand <<= 1, multiplier >>= 1, counter++.
- DIV, each edge (restoring step):
  - Form {remainder, quotient} shifted left by 1.
  - If the shifted remainder >= divisor (unsigned, XLEN+1-bit compare), subtract divisor and set quotient LSB=1; otherwise set LSB=0.
  - counter++.
- Exit from MUL/DIV: on the edge where counter reaches XLEN-1 (the XLEN-th iteration), go to DONE and load result.
- Latency: accept edge ends cycle 0. res_valid is first high in cycle XLEN+1 (33 for XLEN=32). The shortcut paths (divide-by-zero, illegal code) show res_valid in cycle 1.
- DONE:
  - res_valid=1; result and illegal are held stable until handshake.
  - On res_valid & res_ready: return to IDLE. res_valid drops the next cycle.
  - A new request is accepted no earlier than the cycle after the result handshake (no overlap).
- stall = (state != IDLE), including DONE.
- flush (synchronous, highest priority): next state is IDLE from any state. Any pending result is discarded: res_valid=0, illegal=0. A start_valid in the same cycle as flush is not accepted.
- Operands/code changing after accept have no effect.
- Reset asserted mid-operation: immediate return to reset values; no partial result is ever presented.
- If res_ready is held high through the whole operation, the result handshake completes in the first DONE cycle.

Decomposition:
- Shared package alu_pkg:
  - localparams for the ALUControl codes: ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_OR=0011, ALU_XOR=0100, ALU_SLT=0101, ALU_SLTU=0110, ALU_SLL=1010, ALU_SRA=1011, ALU_SRL=1100, ALU_MUL=1000, ALU_DIVU=1001.
  - ALUOp encodings.
  - Sequencer state encoding.
- The decoder and this sequencer both reference alu_pkg.
- One sub-module is natural: muldiv_step, a combinational single-iteration datapath (shift-add and restore-subtract) selected by a mode bit. The FSM, counter and handshake stay in the top.

Test Plan:
- MUL 7*6, res_ready=1 -> stall high from cycle 1; res_valid in cycle 33; result=42, illegal=0; start_ready back to 1 in cycle 34.
- DIVU 100/7, then 0xFFFFFFFF/1 -> results 14 and 0xFFFFFFFF, each after 33 cycles. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 (wrap).
- DIVU 5/0 -> res_valid in cycle 1, result=0xFFFFFFFF, illegal=0. Code 0100 -> res_valid in cycle 1, result=0, illegal=1.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> result, res_valid and stall held; start_valid ignored; handshake on the first res_ready=1, then IDLE.
- flush at cycle 15 of a MUL, with start_valid high in the same cycle -> IDLE next cycle, no res_valid, request not accepted. A following MUL 3*3 gives 9.
- reset asserted asynchronously mid-DIV -> all outputs at reset values before the next edge. A subsequent DIVU 9/3 gives 3.
